// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall detection.
// Holds one decoded instruction for the EX stage. The ALU operands are formed
// combinationally from the latched register-file values. A value from EX/MEM or
// MEM/WB overrides the latched value when that stage writes the same register.
module id_ex_operand_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          id_valid_i,
  input  logic [DW-1:0] id_rs_data_i,
  input  logic [DW-1:0] id_rt_data_i,
  input  logic [DW-1:0] id_imm_i,
  input  logic [AW-1:0] id_rs_i,
  input  logic [AW-1:0] id_rt_i,
  input  logic [AW-1:0] id_rd_i,
  input  logic [3:0]    id_ctrl_i,
  input  logic          id_alu_src_i,
  input  logic          id_reg_write_i,
  input  logic          id_mem_read_i,
  input  logic          id_mem_write_i,
  input  logic          exmem_reg_write_i,
  input  logic [AW-1:0] exmem_rd_i,
  input  logic [DW-1:0] exmem_data_i,
  input  logic          memwb_reg_write_i,
  input  logic [AW-1:0] memwb_rd_i,
  input  logic [DW-1:0] memwb_data_i,
  output logic [DW-1:0] src1_o,
  output logic [DW-1:0] src2_o,
  output logic [3:0]    ctrl_o,
  output logic [DW-1:0] store_data_o,
  output logic [AW-1:0] rd_o,
  output logic          valid_o,
  output logic          reg_write_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic          stall_o
);

  // Control fields; cleared on every bubble.
  logic          valid_q;
  logic          reg_write_q;
  logic          mem_read_q;
  logic          mem_write_q;
  logic [3:0]    ctrl_q;

  // Data fields; only meaningful while valid_q is set.
  logic          alu_src_q;
  logic [AW-1:0] rs_q;
  logic [AW-1:0] rt_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] rs_data_q;
  logic [DW-1:0] rt_data_q;
  logic [DW-1:0] imm_q;

  logic          rs_dep;
  logic          rt_dep;
  logic          load_use;
  logic          bubble;

  logic          ex_hit_rs;
  logic          ex_hit_rt;
  logic          wb_hit_rs;
  logic          wb_hit_rt;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  // Load-use hazard: the load in EX targets a register the ID instruction reads.
  // The rt operand counts when it feeds the ALU or when it is store write data.
  always_comb begin
    rs_dep   = (rd_q == id_rs_i);
    rt_dep   = (rd_q == id_rt_i) & (~id_alu_src_i | id_mem_write_i);
    load_use = valid_q & mem_read_q & (rd_q != '0) & (rs_dep | rt_dep);
    stall_o  = load_use & id_valid_i & ~flush_i;
    bubble   = flush_i | stall_o;
  end

  // Control register: reset clears it, a flush or stall inserts a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      ctrl_q      <= '0;
    end else if (bubble) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      valid_q     <= id_valid_i;
      reg_write_q <= id_reg_write_i;
      mem_read_q  <= id_mem_read_i;
      mem_write_q <= id_mem_write_i;
      ctrl_q      <= id_ctrl_i;
    end
  end

  // Data register: holds its value across a bubble since it is unused then.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alu_src_q <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else if (!bubble) begin
      alu_src_q <= id_alu_src_i;
      rs_q      <= id_rs_i;
      rt_q      <= id_rt_i;
      rd_q      <= id_rd_i;
      rs_data_q <= id_rs_data_i;
      rt_data_q <= id_rt_data_i;
      imm_q     <= id_imm_i;
    end
  end

  // Forwarding select: the younger EX/MEM result beats MEM/WB; $0 is never forwarded.
  always_comb begin
    ex_hit_rs = exmem_reg_write_i & (exmem_rd_i != '0) & (exmem_rd_i == rs_q);
    ex_hit_rt = exmem_reg_write_i & (exmem_rd_i != '0) & (exmem_rd_i == rt_q);
    wb_hit_rs = memwb_reg_write_i & (memwb_rd_i != '0) & (memwb_rd_i == rs_q);
    wb_hit_rt = memwb_reg_write_i & (memwb_rd_i != '0) & (memwb_rd_i == rt_q);

    if (ex_hit_rs)      fwd_rs = exmem_data_i;
    else if (wb_hit_rs) fwd_rs = memwb_data_i;
    else                fwd_rs = rs_data_q;

    if (ex_hit_rt)      fwd_rt = exmem_data_i;
    else if (wb_hit_rt) fwd_rt = memwb_data_i;
    else                fwd_rt = rt_data_q;
  end

  // Output drive: ALU operands plus valid-gated memory/writeback strobes.
  always_comb begin
    src1_o       = fwd_rs;
    src2_o       = alu_src_q ? imm_q : fwd_rt;
    store_data_o = fwd_rt;
    ctrl_o       = ctrl_q;
    rd_o         = rd_q;
    valid_o      = valid_q;
    reg_write_o  = valid_q & reg_write_q;
    mem_read_o   = valid_q & mem_read_q;
    mem_write_o  = valid_q & mem_write_q;
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage: directed vector table, hand-written
// hazard sequences, and randomized traffic checked against an instruction-level model.
module tb_id_ex_operand_stage;

  logic        clk;
  logic        rst_i, flush_i, id_valid_i;
  logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
  logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
  logic [3:0]  id_ctrl_i;
  logic        id_alu_src_i, id_reg_write_i, id_mem_read_i, id_mem_write_i;
  logic        exmem_reg_write_i, memwb_reg_write_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic [31:0] exmem_data_i, memwb_data_i;
  logic [31:0] src1_o, src2_o, store_data_o;
  logic [3:0]  ctrl_o;
  logic [4:0]  rd_o;
  logic        valid_o, reg_write_o, mem_read_o, mem_write_o, stall_o;

  int errors = 0;
  int checks = 0;

  id_ex_operand_stage #(.DW(32), .AW(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .id_ctrl_i(id_ctrl_i),
    .id_alu_src_i(id_alu_src_i), .id_reg_write_i(id_reg_write_i),
    .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
    .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
    .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .src1_o(src1_o), .src2_o(src2_o), .ctrl_o(ctrl_o), .store_data_o(store_data_o),
    .rd_o(rd_o), .valid_o(valid_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .stall_o(stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: the instruction currently in EX ----------------
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_d, rt_d, imm;
    logic [3:0]  ctrl;
    logic        alu_src, rw, mr, mw;
  } instr_t;

  instr_t ex_m = '0;

  function automatic logic model_stall();
    logic uses_rs, uses_rt;
    uses_rs = (id_rs_i == ex_m.rd);
    uses_rt = (id_rt_i == ex_m.rd) && (!id_alu_src_i || id_mem_write_i);
    return ex_m.valid && ex_m.mr && ex_m.rd != 0 && id_valid_i && !flush_i && (uses_rs || uses_rt);
  endfunction

  function automatic logic [31:0] model_fwd(input logic [4:0] a, input logic [31:0] regval);
    if (a == 0) return regval;
    if (exmem_reg_write_i && exmem_rd_i == a) return exmem_data_i;
    if (memwb_reg_write_i && memwb_rd_i == a) return memwb_data_i;
    return regval;
  endfunction

  always @(posedge clk) begin
    instr_t nx;
    if (rst_i) nx = '0;
    else if (flush_i || model_stall()) begin
      nx = ex_m;
      nx.valid = 0; nx.rw = 0; nx.mr = 0; nx.mw = 0; nx.ctrl = 0;
    end else begin
      nx = '{valid: id_valid_i, rs: id_rs_i, rt: id_rt_i, rd: id_rd_i,
             rs_d: id_rs_data_i, rt_d: id_rt_data_i, imm: id_imm_i, ctrl: id_ctrl_i,
             alu_src: id_alu_src_i, rw: id_reg_write_i, mr: id_mem_read_i, mw: id_mem_write_i};
    end
    ex_m = nx;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle; returns at the falling edge, where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst_i = 0; flush_i = 0; id_valid_i = 0;
    id_rs_data_i = 0; id_rt_data_i = 0; id_imm_i = 0;
    id_rs_i = 0; id_rt_i = 0; id_rd_i = 0; id_ctrl_i = 0;
    id_alu_src_i = 0; id_reg_write_i = 0; id_mem_read_i = 0; id_mem_write_i = 0;
    exmem_reg_write_i = 0; exmem_rd_i = 0; exmem_data_i = 0;
    memwb_reg_write_i = 0; memwb_rd_i = 0; memwb_data_i = 0;
  endtask

  task automatic set_load(input logic [4:0] dst);
    idle_inputs();
    id_valid_i = 1; id_rs_i = 1; id_rt_i = dst; id_rd_i = dst;
    id_alu_src_i = 1; id_imm_i = 32'h8; id_mem_read_i = 1; id_reg_write_i = 1; id_ctrl_i = 2;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_d, rt_d, imm;
    logic [3:0]  ctrl;
    logic        alu_src, valid, rw, mw;
    logic        ex_rw; logic [4:0] ex_rd; logic [31:0] ex_d;
    logic        wb_rw; logic [4:0] wb_rd; logic [31:0] wb_d;
    logic [31:0] e_src1, e_src2, e_store;
    logic [3:0]  e_ctrl;
    logic        e_valid, e_rw, e_mw;
  } vec_t;

  vec_t vt[8];
  int unsigned ctrl_codes[7] = '{0, 1, 2, 6, 7, 12, 15};

  initial begin
    // EX/MEM beats MEM/WB on rs
    vt[0] = '{5'd3, 5'd4, 5'd7, 32'h99, 32'h44, 32'h0, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0,
              1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20, 32'h10, 32'h44, 32'h44, 4'd2, 1'b1, 1'b1, 1'b0};
    // $0 is never forwarded
    vt[1] = '{5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0,
              1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'h1234, 32'h0, 32'h0, 32'h0, 4'd1, 1'b1, 1'b1, 1'b0};
    // immediate on src2, store data still forwarded from EX/MEM
    vt[2] = '{5'd1, 5'd6, 5'd0, 32'h11, 32'h66, 32'hFFFFFFFC, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1,
              1'b1, 5'd6, 32'hABCD, 1'b1, 5'd6, 32'h5, 32'h11, 32'hFFFFFFFC, 32'hABCD, 4'd0, 1'b1, 1'b0, 1'b1};
    // MEM/WB only (EX/MEM address matches but no write)
    vt[3] = '{5'd9, 5'd10, 5'd11, 32'h999, 32'hA0, 32'h0, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0,
              1'b0, 5'd9, 32'hDEAD, 1'b1, 5'd9, 32'h900, 32'h900, 32'hA0, 32'hA0, 4'd6, 1'b1, 1'b1, 1'b0};
    // rs from MEM/WB, rt from EX/MEM
    vt[4] = '{5'd12, 5'd13, 5'd14, 32'h1, 32'h2, 32'h0, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0,
              1'b1, 5'd13, 32'h1313, 1'b1, 5'd12, 32'h1212, 32'h1212, 32'h1313, 32'h1313, 4'd7, 1'b1, 1'b1, 1'b0};
    // MEM/WB address matches rs but no write: register value kept
    vt[5] = '{5'd15, 5'd16, 5'd17, 32'hF, 32'h10, 32'h0, 4'd12, 1'b0, 1'b1, 1'b0, 1'b1,
              1'b1, 5'd16, 32'hAAAA, 1'b0, 5'd15, 32'hBBBB, 32'hF, 32'hAAAA, 32'hAAAA, 4'd12, 1'b1, 1'b0, 1'b1};
    // not-valid instruction: strobes gated off
    vt[6] = '{5'd2, 5'd3, 5'd4, 32'h22, 32'h33, 32'h0, 4'd15, 1'b0, 1'b0, 1'b1, 1'b1,
              1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h22, 32'h33, 32'h33, 4'd15, 1'b0, 1'b0, 1'b0};
    // rs via EX/MEM, src2 immediate, store data via MEM/WB on r31
    vt[7] = '{5'd30, 5'd31, 5'd9, 32'h0, 32'h31, 32'h7FFFFFFF, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0,
              1'b1, 5'd30, 32'h1, 1'b1, 5'd31, 32'h3131, 32'h1, 32'h7FFFFFFF, 32'h3131, 4'd15, 1'b1, 1'b1, 1'b0};

    idle_inputs();
    @(negedge clk);

    // ---- reset held two cycles with a valid load presented ----
    set_load(5'd5);
    rst_i = 1;
    tick(); tick();
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_ctrl", 32'(ctrl_o), 32'h0);
    chk("rst_rd", 32'(rd_o), 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_strobes", 32'({reg_write_o, mem_read_o, mem_write_o}), 32'h0);
    chk("rst_src1", src1_o, 32'h0);
    chk("rst_src2", src2_o, 32'h0);
    chk("rst_store", store_data_o, 32'h0);
    idle_inputs();
    tick();

    // ---- vector table ----
    foreach (vt[i]) begin
      id_rs_i = vt[i].rs; id_rt_i = vt[i].rt; id_rd_i = vt[i].rd;
      id_rs_data_i = vt[i].rs_d; id_rt_data_i = vt[i].rt_d; id_imm_i = vt[i].imm;
      id_ctrl_i = vt[i].ctrl; id_alu_src_i = vt[i].alu_src; id_valid_i = vt[i].valid;
      id_reg_write_i = vt[i].rw; id_mem_write_i = vt[i].mw; id_mem_read_i = 0;
      exmem_reg_write_i = vt[i].ex_rw; exmem_rd_i = vt[i].ex_rd; exmem_data_i = vt[i].ex_d;
      memwb_reg_write_i = vt[i].wb_rw; memwb_rd_i = vt[i].wb_rd; memwb_data_i = vt[i].wb_d;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall_o), 32'h0);
      tick();
      chk($sformatf("v%0d_src1", i), src1_o, vt[i].e_src1);
      chk($sformatf("v%0d_src2", i), src2_o, vt[i].e_src2);
      chk($sformatf("v%0d_store", i), store_data_o, vt[i].e_store);
      chk($sformatf("v%0d_ctrl", i), 32'(ctrl_o), 32'(vt[i].e_ctrl));
      chk($sformatf("v%0d_valid", i), 32'(valid_o), 32'(vt[i].e_valid));
      chk($sformatf("v%0d_rw", i), 32'(reg_write_o), 32'(vt[i].e_rw));
      chk($sformatf("v%0d_mw", i), 32'(mem_write_o), 32'(vt[i].e_mw));
      if (vt[i].e_valid) chk($sformatf("v%0d_rd", i), 32'(rd_o), 32'(vt[i].rd));
    end

    // ---- load-use: lw r5 then add r6 = r5 + r2 ----
    set_load(5'd5);
    tick();
    chk("lu_load_in_ex", 32'(mem_read_o), 32'h1);
    idle_inputs();
    id_valid_i = 1; id_rs_i = 5; id_rt_i = 2; id_rd_i = 6; id_ctrl_i = 2;
    id_reg_write_i = 1; id_rs_data_i = 32'hBAD; id_rt_data_i = 32'h2;
    #1;
    chk("lu_stall", 32'(stall_o), 32'h1);
    tick();
    chk("lu_bubble_valid", 32'(valid_o), 32'h0);
    chk("lu_bubble_ctrl", 32'(ctrl_o), 32'h0);
    chk("lu_bubble_strobes", 32'({reg_write_o, mem_read_o, mem_write_o}), 32'h0);
    chk("lu_stall_once", 32'(stall_o), 32'h0);
    exmem_reg_write_i = 1; exmem_rd_i = 5; exmem_data_i = 32'h5555;
    tick();
    exmem_reg_write_i = 0; exmem_rd_i = 0; exmem_data_i = 0;
    memwb_reg_write_i = 1; memwb_rd_i = 5; memwb_data_i = 32'h5A5A;
    #1;
    chk("lu_fwd_src1", src1_o, 32'h5A5A);
    chk("lu_add_valid", 32'(valid_o), 32'h1);
    chk("lu_src2", src2_o, 32'h2);

    // ---- store data rt depends on load even with alu_src=1 ----
    set_load(5'd7);
    tick();
    idle_inputs();
    id_valid_i = 1; id_rs_i = 3; id_rt_i = 7; id_alu_src_i = 1; id_mem_write_i = 1;
    #1;
    chk("st_rt_stall", 32'(stall_o), 32'h1);
    // same rt use on a non-store immediate instruction: no dependency
    id_mem_write_i = 0;
    #1;
    chk("imm_rt_nostall", 32'(stall_o), 32'h0);
    tick();

    // ---- load to $0 never stalls ----
    set_load(5'd0);
    tick();
    idle_inputs();
    id_valid_i = 1; id_rs_i = 0; id_rt_i = 0;
    #1;
    chk("r0_nostall", 32'(stall_o), 32'h0);
    tick();

    // ---- flush wins over stall ----
    set_load(5'd8);
    tick();
    idle_inputs();
    id_valid_i = 1; id_rs_i = 8; id_reg_write_i = 1; flush_i = 1;
    #1;
    chk("fl_stall", 32'(stall_o), 32'h0);
    tick();
    chk("fl_valid", 32'(valid_o), 32'h0);
    chk("fl_rw", 32'(reg_write_o), 32'h0);

    // ---- reset in the middle of a stall ----
    set_load(5'd8);
    tick();
    idle_inputs();
    id_valid_i = 1; id_rs_i = 8;
    #1;
    chk("rs_pre_stall", 32'(stall_o), 32'h1);
    rst_i = 1;
    tick();
    chk("rs_valid", 32'(valid_o), 32'h0);
    chk("rs_stall", 32'(stall_o), 32'h0);
    chk("rs_mr", 32'(mem_read_o), 32'h0);
    rst_i = 0;

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 2000; n++) begin
      rst_i   = ($urandom_range(0, 49) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      id_valid_i = ($urandom_range(0, 3) != 0);
      id_rs_i = 5'($urandom_range(0, 7));
      id_rt_i = 5'($urandom_range(0, 7));
      id_rd_i = 5'($urandom_range(0, 7));
      id_rs_data_i = $urandom; id_rt_data_i = $urandom; id_imm_i = $urandom;
      id_ctrl_i = 4'(ctrl_codes[$urandom_range(0, 6)]);
      id_alu_src_i = 1'($urandom_range(0, 1));
      id_mem_read_i = ($urandom_range(0, 2) == 0);
      id_mem_write_i = !id_mem_read_i && ($urandom_range(0, 3) == 0);
      id_reg_write_i = 1'($urandom_range(0, 1));
      exmem_reg_write_i = 1'($urandom_range(0, 1));
      exmem_rd_i = 5'($urandom_range(0, 7)); exmem_data_i = $urandom;
      memwb_reg_write_i = 1'($urandom_range(0, 1));
      memwb_rd_i = 5'($urandom_range(0, 7)); memwb_data_i = $urandom;
      #1;
      chk("rnd_stall", 32'(stall_o), 32'(model_stall()));
      chk("rnd_valid", 32'(valid_o), 32'(ex_m.valid));
      chk("rnd_ctrl", 32'(ctrl_o), 32'(ex_m.ctrl));
      chk("rnd_strobes", 32'({reg_write_o, mem_read_o, mem_write_o}),
          32'({ex_m.valid & ex_m.rw, ex_m.valid & ex_m.mr, ex_m.valid & ex_m.mw}));
      if (ex_m.valid) begin
        chk("rnd_src1", src1_o, model_fwd(ex_m.rs, ex_m.rs_d));
        chk("rnd_src2", src2_o, ex_m.alu_src ? ex_m.imm : model_fwd(ex_m.rt, ex_m.rt_d));
        chk("rnd_store", store_data_o, model_fwd(ex_m.rt, ex_m.rt_d));
        chk("rnd_rd", 32'(rd_o), 32'(ex_m.rd));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
